// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path constants and the queued fetch-entry record.
package riscv_pkg;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;
    logic        page_fault;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_parcel_fifo.sv
// riscv_parcel_fifo: show-ahead FIFO with synchronous clear; a full push is accepted only alongside a pop.
module riscv_parcel_fifo import riscv_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     wdata_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  T              mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/riscv_if_frontend.sv
// riscv_if_frontend: fetch PC register, BIU handshake, parcel queue to decode and flush distribution.
module riscv_if_frontend import riscv_pkg::*; #(
  parameter int               XLEN        = 32,
  parameter int               PARCEL_SIZE = 32,
  parameter int               DEPTH       = 4,
  parameter logic [XLEN-1:0]  PC_INIT     = '0
) (
  input  logic                     hclk,
  input  logic                     hreset,
  output logic [XLEN-1:0]          bu_nxt_pc,
  input  logic                     bu_stall_nxt_pc,
  output logic                     bu_stall,
  output logic                     bu_flush,
  input  logic [PARCEL_SIZE-1:0]   bu_parcel,
  input  logic [XLEN-1:0]          bu_parcel_pc,
  input  logic [PARCEL_SIZE/16-1:0] bu_parcel_valid,
  input  logic                     bu_parcel_misaligned,
  input  logic                     bu_parcel_page_fault,
  input  logic                     ex_flush,
  input  logic [XLEN-1:0]          ex_flush_pc,
  input  logic                     id_stall,
  output logic                     id_valid,
  output logic [PARCEL_SIZE-1:0]   id_instr,
  output logic [XLEN-1:0]          id_pc,
  output logic                     id_misaligned,
  output logic                     id_page_fault,
  output logic                     ovf
);
  typedef struct packed {
    logic [PARCEL_SIZE-1:0] instr;
    logic [XLEN-1:0]        pc;
    logic                   misaligned;
    logic                   page_fault;
  } entry_t;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, full, empty;
  entry_t          head;
  assign push     = |bu_parcel_valid & ~ex_flush;
  assign id_valid = ~empty & ~ex_flush;
  assign pop      = id_valid & ~id_stall;
  assign bu_stall = full & ~pop;
  assign bu_flush = ex_flush;
  assign bu_nxt_pc = pc_q;
  assign ovf      = ovf_q;
  always_comb begin
    pc_d  = ex_flush ? ex_flush_pc : ~bu_stall_nxt_pc ? pc_q + XLEN'(4) : pc_q;
    ovf_d = ovf_q | (push & full & ~pop);
    id_instr      = empty ? PARCEL_SIZE'(INSTR_NOP) : head.instr;
    id_pc         = empty ? '0 : head.pc;
    id_misaligned = ~empty & head.misaligned;
    id_page_fault = ~empty & head.page_fault;
  end
  always_ff @(posedge hclk) begin
    if (hreset) begin
      pc_q  <= PC_INIT;
      ovf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
    end
  end
  riscv_parcel_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk     (hclk),
    .rst     (hreset),
    .clr_i   (ex_flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ('{bu_parcel, bu_parcel_pc, bu_parcel_misaligned, bu_parcel_page_fault}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_riscv_if_frontend.sv
// tb_riscv_if_frontend: directed vector table, hand sequences and random traffic against a queue model.
module tb_riscv_if_frontend;
  localparam int DEPTH = 4;
  localparam logic [31:0] K = 32'h1357_0000;
  logic        hclk = 1'b0, hreset = 1'b1;
  logic [31:0] bu_nxt_pc, bu_parcel = '0, bu_parcel_pc = '0, ex_flush_pc = '0;
  logic [31:0] id_instr, id_pc;
  logic [1:0]  bu_parcel_valid = '0;
  logic        bu_stall_nxt_pc = 1'b1, bu_stall, bu_flush, bu_parcel_misaligned = 1'b0;
  logic        bu_parcel_page_fault = 1'b0, ex_flush = 1'b0, id_stall = 1'b0;
  logic        id_valid, id_misaligned, id_page_fault, ovf;
  int checks = 0, errors = 0;

  riscv_if_frontend #(.XLEN(32), .PARCEL_SIZE(32), .DEPTH(DEPTH), .PC_INIT(32'h0)) dut (
    .hclk(hclk), .hreset(hreset), .bu_nxt_pc(bu_nxt_pc), .bu_stall_nxt_pc(bu_stall_nxt_pc),
    .bu_stall(bu_stall), .bu_flush(bu_flush), .bu_parcel(bu_parcel), .bu_parcel_pc(bu_parcel_pc),
    .bu_parcel_valid(bu_parcel_valid), .bu_parcel_misaligned(bu_parcel_misaligned),
    .bu_parcel_page_fault(bu_parcel_page_fault), .ex_flush(ex_flush), .ex_flush_pc(ex_flush_pc),
    .id_stall(id_stall), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_misaligned(id_misaligned), .id_page_fault(id_page_fault), .ovf(ovf)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge hclk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  pv;
    logic [31:0] ppc;
    logic        pf, stall, flush;
    logic        ev;
    logic [31:0] epc;
    logic        ebs, eovf, epf;
    logic [31:0] enpc;
  } vec_t;
  vec_t tbl [16];

  typedef struct {
    logic [31:0] instr, pc;
    logic        mis, pf;
  } ent_t;
  ent_t        q[$];
  logic [31:0] pcm;
  logic        ovfm, popm;

  initial begin
    tbl[0]  = '{2'b01, 32'h00,  0, 1, 0,  0, 32'h00, 0, 0, 0, 32'h0};
    tbl[1]  = '{2'b11, 32'h04,  0, 1, 0,  1, 32'h00, 0, 0, 0, 32'h0};
    tbl[2]  = '{2'b10, 32'h08,  0, 1, 0,  1, 32'h00, 0, 0, 0, 32'h0};
    tbl[3]  = '{2'b01, 32'h0C,  0, 1, 0,  1, 32'h00, 0, 0, 0, 32'h0};
    tbl[4]  = '{2'b00, 32'h00,  0, 1, 0,  1, 32'h00, 1, 0, 0, 32'h0};
    tbl[5]  = '{2'b11, 32'h10,  0, 0, 0,  1, 32'h00, 0, 0, 0, 32'h0};
    tbl[6]  = '{2'b00, 32'h00,  0, 1, 0,  1, 32'h04, 1, 0, 0, 32'h0};
    tbl[7]  = '{2'b01, 32'h14,  0, 1, 0,  1, 32'h04, 1, 0, 0, 32'h0};
    tbl[8]  = '{2'b00, 32'h00,  0, 0, 0,  1, 32'h04, 0, 1, 0, 32'h0};
    tbl[9]  = '{2'b01, 32'h200, 0, 0, 1,  0, 32'h08, 0, 1, 0, 32'h0};
    tbl[10] = '{2'b00, 32'h00,  0, 0, 0,  0, 32'h00, 0, 1, 0, 32'h100};
    tbl[11] = '{2'b01, 32'h20,  1, 1, 0,  0, 32'h00, 0, 1, 0, 32'h100};
    tbl[12] = '{2'b01, 32'h24,  0, 1, 0,  1, 32'h20, 0, 1, 1, 32'h100};
    tbl[13] = '{2'b00, 32'h00,  0, 0, 0,  1, 32'h20, 0, 1, 1, 32'h100};
    tbl[14] = '{2'b00, 32'h00,  0, 0, 0,  1, 32'h24, 0, 1, 0, 32'h100};
    tbl[15] = '{2'b00, 32'h00,  0, 1, 0,  0, 32'h00, 0, 1, 0, 32'h100};

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_nxt_pc", bu_nxt_pc, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_bu_stall", bu_stall, 0);
    chk("rst_id_instr", id_instr, 32'h13);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_faults", {id_misaligned, id_page_fault}, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_bu_flush", bu_flush, 0);
    step;
    hreset = 1'b0;
    ex_flush_pc = 32'h100;

    for (int i = 0; i < 16; i++) begin
      bu_parcel_valid = tbl[i].pv;
      bu_parcel_pc = tbl[i].ppc;
      bu_parcel = tbl[i].ppc ^ K;
      bu_parcel_page_fault = tbl[i].pf;
      id_stall = tbl[i].stall;
      ex_flush = tbl[i].flush;
      @(negedge hclk);
      chk($sformatf("v%0d_id_valid", i), id_valid, tbl[i].ev);
      chk($sformatf("v%0d_id_pc", i), id_pc, tbl[i].epc);
      chk($sformatf("v%0d_bu_stall", i), bu_stall, tbl[i].ebs);
      chk($sformatf("v%0d_ovf", i), ovf, tbl[i].eovf);
      chk($sformatf("v%0d_page_fault", i), id_page_fault, tbl[i].epf);
      chk($sformatf("v%0d_nxt_pc", i), bu_nxt_pc, tbl[i].enpc);
      chk($sformatf("v%0d_bu_flush", i), bu_flush, tbl[i].flush);
      if (tbl[i].ev) chk($sformatf("v%0d_id_instr", i), id_instr, tbl[i].epc ^ K);
      else if (tbl[i].epc == 0) chk($sformatf("v%0d_nop", i), id_instr, 32'h13);
      step;
    end

    bu_parcel_valid = '0;
    ex_flush = 1'b1;
    ex_flush_pc = 32'hFFFF_FFF8;
    step;
    ex_flush = 1'b0;
    bu_stall_nxt_pc = 1'b0;
    @(negedge hclk);
    chk("adv_flush_pc", bu_nxt_pc, 32'hFFFF_FFF8);
    chk("ovf_sticky_flush", ovf, 1);
    step;
    @(negedge hclk);
    chk("adv_plus4", bu_nxt_pc, 32'hFFFF_FFFC);
    step;
    bu_stall_nxt_pc = 1'b1;
    @(negedge hclk);
    chk("adv_wrap", bu_nxt_pc, 32'h0);
    step;
    @(negedge hclk);
    chk("adv_hold", bu_nxt_pc, 32'h0);
    step;
    hreset = 1'b1;
    step;
    @(negedge hclk);
    chk("reset_clears_ovf", ovf, 0);
    step;
    hreset = 1'b0;

    q.delete();
    pcm = 32'h0;
    ovfm = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      hreset = ($urandom % 200) == 0;
      ex_flush = ($urandom % 16) == 0;
      ex_flush_pc = $urandom & 32'hFFFF_FFFC;
      id_stall = ($urandom % 2) == 0;
      bu_stall_nxt_pc = ($urandom % 3) == 0;
      bu_parcel_valid = ($urandom % 5) < 3 ? 2'($urandom_range(1, 3)) : 2'b00;
      bu_parcel = $urandom;
      bu_parcel_pc = $urandom;
      bu_parcel_misaligned = ($urandom % 4) == 0;
      bu_parcel_page_fault = ($urandom % 4) == 0;
      @(negedge hclk);
      popm = q.size() != 0 && !ex_flush && !id_stall;
      chk("rnd_id_valid", id_valid, q.size() != 0 && !ex_flush);
      chk("rnd_bu_stall", bu_stall, q.size() == DEPTH && !popm);
      chk("rnd_nxt_pc", bu_nxt_pc, pcm);
      chk("rnd_ovf", ovf, ovfm);
      if (q.size() != 0) begin
        chk("rnd_id_pc", id_pc, q[0].pc);
        chk("rnd_id_instr", id_instr, q[0].instr);
        chk("rnd_faults", {id_misaligned, id_page_fault}, {q[0].mis, q[0].pf});
      end else begin
        chk("rnd_empty_instr", id_instr, 32'h13);
        chk("rnd_empty_pc", id_pc, 0);
      end
      if (hreset) begin
        q.delete();
        pcm = 32'h0;
        ovfm = 1'b0;
      end else if (ex_flush) begin
        q.delete();
        pcm = ex_flush_pc;
      end else begin
        if (popm) void'(q.pop_front());
        if (bu_parcel_valid != 0) begin
          if (q.size() < DEPTH)
            q.push_back('{bu_parcel, bu_parcel_pc, bu_parcel_misaligned, bu_parcel_page_fault});
          else
            ovfm = 1'b1;
        end
        if (!bu_stall_nxt_pc) pcm = pcm + 32'd4;
      end
      step;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
